// File: rtl/regf_wb_ctrl_if.sv
// Writeback-controller bus: ALU result, load result handshake, issue
// notifications, scoreboard queries and the register-file write port.
interface regf_wb_ctrl_if #(
  parameter int LD_DEPTH = 2
);
  localparam int CW = $clog2(LD_DEPTH) + 1;

  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [4:0]  qa;
  logic [4:0]  qb;
  logic        busy_a;
  logic        busy_b;
  logic        regwn;
  logic [4:0]  addrd;
  logic [31:0] datad;
  logic [CW-1:0] ld_count;

  // Pipeline side that produces results and queries the scoreboard
  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_valid, ld_rd, ld_data,
    output iss_valid, iss_rd, qa, qb,
    input  ld_ready, busy_a, busy_b, regwn, addrd, datad, ld_count
  );

  // Writeback controller side
  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_valid, ld_rd, ld_data,
    input  iss_valid, iss_rd, qa, qb,
    output ld_ready, busy_a, busy_b, regwn, addrd, datad, ld_count
  );
endinterface

// File: rtl/regf_wb_ctrl.sv
// Register-file writeback controller: merges the ALU and load result
// streams onto the single write port (ALU has priority, losing loads are
// buffered in order) and keeps the per-register busy scoreboard.
module regf_wb_ctrl #(
  parameter int LD_DEPTH = 2
) (
  input logic           clk,
  input logic           rst,
  regf_wb_ctrl_if.slave bus
);
  localparam int AW = $clog2(LD_DEPTH);
  localparam int CW = AW + 1;

  // Load-result buffer storage and bookkeeping
  logic [4:0]    r_fifo_rd   [LD_DEPTH];
  logic [31:0]   r_fifo_data [LD_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  // Registered write port
  logic          r_regwn;
  logic [4:0]    r_addrd;
  logic [31:0]   r_datad;

  // Scoreboard; bit 0 is never set so x0 always reads as free
  logic [31:0]   r_busy;
  logic [31:0]   w_busy_next;

  logic w_full;
  logic w_empty;
  logic w_ld_ready;
  logic w_push;
  logic w_alu_win;
  logic w_pop;

  assign w_full     = (r_count == CW'(LD_DEPTH));
  assign w_empty    = (r_count == '0);
  // Ready ignores a same-cycle pop so the handshake never depends on arbitration
  assign w_ld_ready = !w_full && !rst;
  // x0 loads complete the handshake but are never stored
  assign w_push     = bus.ld_valid && w_ld_ready && (bus.ld_rd != 5'd0);
  // x0 ALU results are dropped and leave the port to the load buffer
  assign w_alu_win  = bus.alu_valid && (bus.alu_rd != 5'd0);
  assign w_pop      = !w_alu_win && !w_empty;

  // Buffer storage is written only on push; contents need no reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_rd[r_wptr]   <= bus.ld_rd;
      r_fifo_data[r_wptr] <= bus.ld_data;
    end
  end

  // Buffer pointers and occupancy; power-of-two depth lets pointers wrap naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Write-port arbitration: ALU first, then buffer head, else idle holding addr/data
  always_ff @(posedge clk) begin
    if (rst) begin
      r_regwn <= 1'b0;
      r_addrd <= 5'd0;
      r_datad <= 32'd0;
    end else if (w_alu_win) begin
      r_regwn <= 1'b1;
      r_addrd <= bus.alu_rd;
      r_datad <= bus.alu_data;
    end else if (w_pop) begin
      r_regwn <= 1'b1;
      r_addrd <= r_fifo_rd[r_rptr];
      r_datad <= r_fifo_data[r_rptr];
    end else begin
      r_regwn <= 1'b0;
    end
  end

  // Per-register next busy state: an issue set overrides a same-edge writeback clear
  assign w_busy_next[0] = 1'b0;
  for (genvar gi = 1; gi < 32; gi++) begin : g_busy
    assign w_busy_next[gi] = (bus.iss_valid && (bus.iss_rd == 5'(gi))) ||
                             (r_busy[gi] && !(r_regwn && (r_addrd == 5'(gi))));
  end

  // Scoreboard register
  always_ff @(posedge clk) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_busy_next;
  end

  assign bus.ld_ready = w_ld_ready;
  assign bus.ld_count = r_count;
  assign bus.regwn    = r_regwn;
  assign bus.addrd    = r_addrd;
  assign bus.datad    = r_datad;
  assign bus.busy_a   = r_busy[bus.qa];
  assign bus.busy_b   = r_busy[bus.qb];
endmodule

// File: tb/tb_regf_wb_ctrl.sv
// Directed bench for regf_wb_ctrl with LD_DEPTH=2; expected values are
// hand-computed per step.
module tb_regf_wb_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  regf_wb_ctrl_if #(.LD_DEPTH(2)) bus ();

  regf_wb_ctrl #(.LD_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge; outputs then show the new cycle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alu_valid = 1'b0; bus.alu_rd = 5'd0; bus.alu_data = 32'd0;
    bus.ld_valid  = 1'b0; bus.ld_rd  = 5'd0; bus.ld_data  = 32'd0;
    bus.iss_valid = 1'b0; bus.iss_rd = 5'd0;
  endtask

  initial begin
    idle_inputs();
    bus.qa = 5'd0;
    bus.qb = 5'd0;
    rst = 1'b1;

    // ---------------- reset with random inputs ----------------
    for (int c = 0; c < 2; c++) begin
      bus.alu_valid = 1'($urandom); bus.alu_rd = 5'($urandom); bus.alu_data = $urandom;
      bus.ld_valid  = 1'($urandom); bus.ld_rd  = 5'($urandom); bus.ld_data  = $urandom;
      bus.iss_valid = 1'($urandom); bus.iss_rd = 5'($urandom);
      tick();
      chk("rst_regwn", bus.regwn, 0);
      chk("rst_addrd", bus.addrd, 0);
      chk("rst_datad", bus.datad, 0);
      chk("rst_ld_ready", bus.ld_ready, 0);
    end
    for (int r = 0; r < 32; r++) begin
      bus.qa = 5'(r);
      bus.qb = 5'(31 - r);
      #1;
      chk("rst_busy_a", bus.busy_a, 0);
      chk("rst_busy_b", bus.busy_b, 0);
    end
    idle_inputs();
    rst = 1'b0;
    #1;
    chk("rel_ld_ready", bus.ld_ready, 1);
    chk("rel_ld_count", bus.ld_count, 0);

    // ---------------- ALU write with scoreboard ----------------
    bus.qa = 5'd5;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd5;
    tick();                                   // edge 0
    bus.iss_valid = 1'b0;
    chk("sb_busy_c1", bus.busy_a, 1);
    tick();                                   // edge 1
    chk("sb_busy_c2", bus.busy_a, 1);
    tick();                                   // edge 2
    chk("sb_busy_c3", bus.busy_a, 1);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
    tick();                                   // edge 3
    bus.alu_valid = 1'b0;
    chk("alu_regwn", bus.regwn, 1);
    chk("alu_addrd", bus.addrd, 5);
    chk("alu_datad", bus.datad, 32'hDEADBEEF);
    chk("alu_busy_c4", bus.busy_a, 1);
    tick();                                   // edge 4
    chk("alu_busy_c5", bus.busy_a, 0);
    chk("alu_regwn_c5", bus.regwn, 0);
    chk("alu_addrd_hold", bus.addrd, 5);

    // ---------------- contention and buffering ----------------
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'h101;
    bus.ld_valid  = 1'b1; bus.ld_rd  = 5'd10; bus.ld_data = 32'hA;
    tick();                                   // x10 accepted, x1 written
    chk("ct_w1_addrd", bus.addrd, 1);
    chk("ct_cnt1", bus.ld_count, 1);
    chk("ct_rdy1", bus.ld_ready, 1);
    bus.alu_rd = 5'd2; bus.alu_data = 32'h102;
    bus.ld_rd  = 5'd11; bus.ld_data = 32'hB;
    tick();                                   // x11 accepted, buffer full
    chk("ct_w2_addrd", bus.addrd, 2);
    chk("ct_cnt2", bus.ld_count, 2);
    chk("ct_rdy_full", bus.ld_ready, 0);
    bus.alu_rd = 5'd3; bus.alu_data = 32'h103;
    bus.ld_rd  = 5'd12; bus.ld_data = 32'hC;
    tick();                                   // x12 refused
    chk("ct_w3_addrd", bus.addrd, 3);
    chk("ct_cnt_hold", bus.ld_count, 2);
    chk("ct_rdy_hold", bus.ld_ready, 0);
    bus.alu_rd = 5'd4; bus.alu_data = 32'h104;
    tick();
    chk("ct_w4_regwn", bus.regwn, 1);
    chk("ct_w4_addrd", bus.addrd, 4);
    chk("ct_w4_datad", bus.datad, 32'h104);
    chk("ct_rdy_starved", bus.ld_ready, 0);
    bus.alu_valid = 1'b0;
    tick();                                   // pop x10
    chk("ct_x10_regwn", bus.regwn, 1);
    chk("ct_x10_addrd", bus.addrd, 10);
    chk("ct_x10_datad", bus.datad, 32'hA);
    chk("ct_cnt_after_pop", bus.ld_count, 1);
    chk("ct_rdy_free", bus.ld_ready, 1);
    tick();                                   // pop x11, push x12
    bus.ld_valid = 1'b0;
    chk("ct_x11_regwn", bus.regwn, 1);
    chk("ct_x11_addrd", bus.addrd, 11);
    chk("ct_x11_datad", bus.datad, 32'hB);
    chk("ct_cnt_pushpop", bus.ld_count, 1);
    tick();                                   // pop x12
    chk("ct_x12_regwn", bus.regwn, 1);
    chk("ct_x12_addrd", bus.addrd, 12);
    chk("ct_x12_datad", bus.datad, 32'hC);
    chk("ct_cnt_empty", bus.ld_count, 0);
    tick();
    chk("ct_idle_regwn", bus.regwn, 0);

    // ---------------- x0 handling ----------------
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd6; bus.alu_data = 32'h66;
    bus.ld_valid  = 1'b1; bus.ld_rd  = 5'd7; bus.ld_data  = 32'h77;
    tick();                                   // x7 buffered behind x6
    chk("x0_cnt_buf", bus.ld_count, 1);
    chk("x0_w6_addrd", bus.addrd, 6);
    bus.ld_valid = 1'b0;
    bus.alu_rd = 5'd0; bus.alu_data = 32'hBAD;
    tick();                                   // x0 ALU dropped, x7 popped
    bus.alu_valid = 1'b0;
    chk("x0_x7_regwn", bus.regwn, 1);
    chk("x0_x7_addrd", bus.addrd, 7);
    chk("x0_x7_datad", bus.datad, 32'h77);
    chk("x0_cnt_zero", bus.ld_count, 0);
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd0; bus.qa = 5'd0;
    tick();
    bus.iss_valid = 1'b0;
    chk("x0_busy_x0", bus.busy_a, 0);
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd0; bus.ld_data = 32'h55;
    #1;
    chk("x0_ld_ready", bus.ld_ready, 1);
    tick();
    bus.ld_valid = 1'b0;
    chk("x0_ld_cnt", bus.ld_count, 0);
    chk("x0_ld_regwn1", bus.regwn, 0);
    tick();
    chk("x0_ld_regwn2", bus.regwn, 0);

    // ---------------- simultaneous set/clear ----------------
    bus.qb = 5'd9;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 32'h99;
    tick();
    bus.alu_valid = 1'b0;
    chk("sc_regwn", bus.regwn, 1);
    chk("sc_addrd", bus.addrd, 9);
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
    tick();                                   // clear and set on same edge
    bus.iss_valid = 1'b0;
    chk("sc_busy9", bus.busy_b, 1);
    tick();
    chk("sc_busy9_hold", bus.busy_b, 1);

    // ---------------- reset mid-operation ----------------
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd13; bus.alu_data = 32'h13;
    bus.ld_valid  = 1'b1; bus.ld_rd  = 5'd20; bus.ld_data  = 32'h20;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd20;
    tick();
    bus.alu_rd = 5'd14; bus.alu_data = 32'h14;
    bus.ld_rd  = 5'd21; bus.ld_data  = 32'h21;
    bus.iss_rd = 5'd21;
    tick();
    chk("mr_cnt_full", bus.ld_count, 2);
    bus.qa = 5'd20;
    #1;
    chk("mr_busy20_pre", bus.busy_a, 1);
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mr_cnt", bus.ld_count, 0);
    chk("mr_regwn0", bus.regwn, 0);
    for (int r = 0; r < 32; r++) begin
      bus.qa = 5'(r);
      #1;
      chk("mr_busy", bus.busy_a, 0);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("mr_no_regwn", bus.regwn, 0);
      chk("mr_cnt_stay", bus.ld_count, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
